hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core: detects load-use, branch-operand and multiply/divide-busy hazards, generates PC/IF-ID stall, IF-ID flush and ID-EX bubble controls, and turns an asynchronous `irq` into a single synchronised flush/take pulse. It sits beside the ID stage and replaces the single-cycle, fixed-width hazard logic. Hazards on register 0 are never flagged, and the load-use window scales with memory latency.

## Interface
- `REG_AW`, 5: register-address width.
- `LOAD_LAT`, 1: load data latency in cycles beyond EX (1 or 2); 2 extends load-use detection into MEM.
- `MD_LAT`, 8: mult/div busy cycles after issue (1..63).
- `IRQ_SYNC`, 2: irq synchroniser depth (≥2).

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `id_rs`, `id_rt`  in  REG_AW  ID-stage source registers.
- `id_use_rs`, `id_use_rt`  in  1  ID instruction actually reads rs/rt.
- `id_branch`  in  1  ID holds a conditional branch (operands compared in ID).
- `id_br_taken`  in  1  branch resolved taken.
- `id_jump`  in  1  ID holds j/jal/jr/jalr.
- `id_md_start`  in  1  ID holds mult/multu/div/divu.
- `id_md_read`  in  1  ID holds mfhi/mflo.
- `ex_mem_rd`, `ex_reg_write`  in  1  EX instruction is a load / writes a register.
- `ex_dst`  in  REG_AW  EX destination (RegDst already resolved).
- `mem_mem_rd`, `mem_reg_write`  in  1  MEM-stage equivalents.
- `mem_dst`  in  REG_AW  MEM destination.
- `irq`  in  1  asynchronous interrupt request, level.
- `pc_stall`  out  1  hold PC.
- `if_id_stall`  out  1  hold IF/ID.
- `if_id_flush`  out  1  clear IF/ID.
- `id_ex_flush`  out  1  insert bubble into ID/EX.
- `irq_take`  out  1  one-cycle pulse: interrupt accepted this cycle.
- `md_busy`  out  1  mult/div unit occupied.

## Operation
- Match(x,d) = use_x & (id_x == d) & (d != 0).
- Load-use: `ex_mem_rd` & Match(rs|rt, ex_dst). If `LOAD_LAT`=2 also `mem_mem_rd` & Match(rs|rt, mem_dst).
- Branch-operand (only when `id_branch` or jr/jalr via `id_jump` with `id_use_rs`): `ex_reg_write` & Match(…, ex_dst), or `mem_mem_rd` & Match(…, mem_dst).
- MD hazard: (`id_md_read` | `id_md_start`) & `md_busy`.
- stall = any of the above. On stall: `pc_stall`=`if_id_stall`=`id_ex_flush`=1, `if_id_flush`=0, branch/jump ignored.
- No stall: `if_id_flush` = `id_jump` | (`id_branch` & `id_br_taken`) | `irq_take`.
- MD counter: `id_md_start` & ~stall loads `MD_LAT`; nonzero decrements each cycle; `md_busy` = counter≠0.
- IRQ FSM: IDLE → PEND on synchronised rising edge; PEND → TAKE when stall=0; TAKE (one cycle, `irq_take`=1) → WAIT; WAIT → IDLE when synchronised irq low. Edges during PEND/TAKE/WAIT are merged (no second take).

## Timing
- All stall/flush outputs combinational from inputs plus registered state; same-cycle response.
- irq edge to `irq_take`: `IRQ_SYNC`+1 cycles minimum, extended by any stall.
- `md_busy` rises the cycle after issue, stays high exactly `MD_LAT` cycles.
- Reset (`reset`=0 at posedge): sync flops 0, FSM IDLE, counter 0; all outputs 0 from the next cycle, combinational outputs still driven by inputs. Reset mid-PEND or mid-MD discards both.
- Simultaneous jump and `irq_take`: single `if_id_flush`, `irq_take` still pulses.

## Configuration
- `HAZARD_MD_EN`: defined → MD counter and MD hazard present. Undefined → `md_busy` tied 0, `id_md_start`/`id_md_read` ignored, no counter flops.

## Test plan
- lw $8 in EX, ID add reads $8 → one cycle `pc_stall`=`id_ex_flush`=1; with `LOAD_LAT`=2 second stall cycle when lw in MEM.
- lw $0 in EX, ID reads $0 → no stall.
- addi $9 in EX, ID beq $9,$3 taken → stall one cycle, then `if_id_flush`=1 once.
- mult issued, mfhi 3 cycles later, `MD_LAT`=8 → stall 6 cycles, release when `md_busy` falls.
- irq pulse during load-use stall → `irq_take` delayed to first non-stall cycle, exactly one pulse; second irq edge while WAIT ignored.
- `reset`=0 while PEND and counter=5 → next cycle `irq_take`=0, `md_busy`=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Detects load-use, branch-operand and mult/div-busy hazards, drives the
// PC / IF-ID stall, IF-ID flush and ID-EX bubble controls, and converts an
// asynchronous level irq into a single synchronised take pulse.
// Optional feature macro: HAZARD_MD_EN (mult/div busy counter and hazard).
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 8,
    parameter int IRQ_SYNC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_branch,
    input  logic              id_br_taken,
    input  logic              id_jump,
    input  logic              id_md_start,
    input  logic              id_md_read,
    input  logic              ex_mem_rd,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              mem_mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              irq,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              irq_take,
    output logic              md_busy
);

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_PEND,
        IRQ_TAKE,
        IRQ_WAIT
    } irq_state_t;

    // A source register depends on a destination only if it is really read
    // and the destination is not the hard-wired zero register.
    function automatic logic reg_match(input logic              use_r,
                                       input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] dst);
        return use_r && (src == dst) && (dst != '0);
    endfunction

    logic                dep_ex;
    logic                dep_mem;
    logic                load_use_ex;
    logic                load_use_mem;
    logic                br_ops_needed;
    logic                branch_hazard;
    logic                md_hazard;
    logic                stall;
    logic [IRQ_SYNC-1:0] irq_sync;
    logic                irq_s_d;
    logic                irq_s;
    logic                irq_rise;
    irq_state_t          irq_state;
    irq_state_t          irq_state_nxt;

    // MEM-stage ALU results are forwarded, so the write flag itself is not needed.
    logic unused_mem_reg_write;
    assign unused_mem_reg_write = mem_reg_write;

    assign dep_ex  = reg_match(id_use_rs, id_rs, ex_dst)  | reg_match(id_use_rt, id_rt, ex_dst);
    assign dep_mem = reg_match(id_use_rs, id_rs, mem_dst) | reg_match(id_use_rt, id_rt, mem_dst);

    // Load data arrives one cycle after EX; with two-cycle loads the MEM
    // stage load is still in flight as well.
    assign load_use_ex  = ex_mem_rd & dep_ex;
    assign load_use_mem = (LOAD_LAT >= 2) & mem_mem_rd & dep_mem;

    // Branches and register jumps compare/consume operands in ID, before the
    // EX forwarding point, so any EX writer or a MEM load blocks them.
    assign br_ops_needed = id_branch | (id_jump & id_use_rs);
    assign branch_hazard = br_ops_needed & ((ex_reg_write & dep_ex) | (mem_mem_rd & dep_mem));

`ifdef HAZARD_MD_EN
    localparam int MD_CW = $clog2(MD_LAT + 1);

    logic [MD_CW-1:0] md_cnt;

    // Busy counter: loaded on an accepted mult/div issue, counts down to idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (id_md_start && !stall) begin
            md_cnt <= MD_CW'(MD_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - MD_CW'(1);
        end
    end

    assign md_busy   = (md_cnt != '0);
    assign md_hazard = (id_md_read | id_md_start) & md_busy;
`else
    logic unused_md_inputs;
    assign unused_md_inputs = id_md_start ^ id_md_read;
    assign md_busy          = 1'b0;
    assign md_hazard        = 1'b0;
`endif

    assign stall = load_use_ex | load_use_mem | branch_hazard | md_hazard;

    // A stall freezes the front end and bubbles EX; a redirect is only acted
    // on once the instruction in ID is actually allowed to proceed.
    assign pc_stall    = stall;
    assign if_id_stall = stall;
    assign id_ex_flush = stall;
    assign if_id_flush = ~stall & (id_jump | (id_branch & id_br_taken) | irq_take);

    assign irq_s    = irq_sync[IRQ_SYNC-1];
    assign irq_rise = irq_s & ~irq_s_d;

    // Synchroniser chain plus one delayed copy for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_sync <= '0;
            irq_s_d  <= 1'b0;
        end else begin
            irq_sync <= {irq_sync[IRQ_SYNC-2:0], irq};
            irq_s_d  <= irq_s;
        end
    end

    // Interrupt FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_state <= IRQ_IDLE;
        end else begin
            irq_state <= irq_state_nxt;
        end
    end

    // Interrupt FSM next state: take only on a non-stalled cycle, then wait
    // for the request to drop so one level episode yields one take.
    always_comb begin
        irq_state_nxt = irq_state;
        irq_take      = 1'b0;
        case (irq_state)
            IRQ_IDLE: begin
                if (irq_rise) begin
                    irq_state_nxt = IRQ_PEND;
                end
            end
            IRQ_PEND: begin
                if (!stall) begin
                    irq_state_nxt = IRQ_TAKE;
                end
            end
            IRQ_TAKE: begin
                irq_take      = 1'b1;
                irq_state_nxt = IRQ_WAIT;
            end
            IRQ_WAIT: begin
                if (!irq_s) begin
                    irq_state_nxt = IRQ_IDLE;
                end
            end
            default: begin
                irq_state_nxt = IRQ_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: bench for hazard_ctrl. Two instances share all inputs,
// one with single-cycle loads and one with two-cycle loads.
module tb_hazard_ctrl;

    localparam int REG_AW   = 5;
    localparam int MD_LAT   = 8;
    localparam int IRQ_SYNC = 2;
`ifdef HAZARD_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] id_rs, id_rt, ex_dst, mem_dst;
    logic              id_use_rs, id_use_rt, id_branch, id_br_taken, id_jump;
    logic              id_md_start, id_md_read;
    logic              ex_mem_rd, ex_reg_write, mem_mem_rd, mem_reg_write, irq;
    logic [1:0]        pc_stall, if_id_stall, if_id_flush, id_ex_flush, irq_take, md_busy;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(REG_AW), .LOAD_LAT(1), .MD_LAT(MD_LAT), .IRQ_SYNC(IRQ_SYNC)) u_lat1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_br_taken(id_br_taken), .id_jump(id_jump), .id_md_start(id_md_start),
        .id_md_read(id_md_read), .ex_mem_rd(ex_mem_rd), .ex_reg_write(ex_reg_write),
        .ex_dst(ex_dst), .mem_mem_rd(mem_mem_rd), .mem_reg_write(mem_reg_write),
        .mem_dst(mem_dst), .irq(irq), .pc_stall(pc_stall[0]), .if_id_stall(if_id_stall[0]),
        .if_id_flush(if_id_flush[0]), .id_ex_flush(id_ex_flush[0]), .irq_take(irq_take[0]),
        .md_busy(md_busy[0]));

    hazard_ctrl #(.REG_AW(REG_AW), .LOAD_LAT(2), .MD_LAT(MD_LAT), .IRQ_SYNC(IRQ_SYNC)) u_lat2 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_br_taken(id_br_taken), .id_jump(id_jump), .id_md_start(id_md_start),
        .id_md_read(id_md_read), .ex_mem_rd(ex_mem_rd), .ex_reg_write(ex_reg_write),
        .ex_dst(ex_dst), .mem_mem_rd(mem_mem_rd), .mem_reg_write(mem_reg_write),
        .mem_dst(mem_dst), .irq(irq), .pc_stall(pc_stall[1]), .if_id_stall(if_id_stall[1]),
        .if_id_flush(if_id_flush[1]), .id_ex_flush(id_ex_flush[1]), .irq_take(irq_take[1]),
        .md_busy(md_busy[1]));

    int checks   = 0;
    int failures = 0;

    // Reference model state, per instance (index 0: 1-cycle loads, 1: 2-cycle).
    int m_md_left [2];
    bit m_pend    [2];
    bit m_take    [2];
    bit m_wait    [2];
    // Sampled irq history, [0] = most recent sample.
    bit hist [IRQ_SYNC+1];

    bit last_stall [2];
    bit last_take  [2];
    bit last_busy  [2];

    typedef struct {
        string       name;
        logic [4:0]  rs, rt;
        logic        urs, urt, br, tk, jmp, mdrd;
        logic        exmr, exrw;
        logic [4:0]  exdst;
        logic        memmr;
        logic [4:0]  memdst;
        logic        s1, s2, f1, f2;
    } vec_t;

    vec_t vq[$];

    function automatic bit dep(logic u, logic [4:0] r, logic [4:0] d);
        return (u === 1'b1) && (r == d) && (d != 5'd0);
    endfunction

    function automatic bit model_stall(int d);
        bit dex, dmem, lu, bo, md;
        dex  = dep(id_use_rs, id_rs, ex_dst)  || dep(id_use_rt, id_rt, ex_dst);
        dmem = dep(id_use_rs, id_rs, mem_dst) || dep(id_use_rt, id_rt, mem_dst);
        lu   = (ex_mem_rd === 1'b1) && dex;
        if (d == 1) lu = lu || ((mem_mem_rd === 1'b1) && dmem);
        bo   = ((id_branch === 1'b1) || (id_jump === 1'b1 && id_use_rs === 1'b1)) &&
               (((ex_reg_write === 1'b1) && dex) || ((mem_mem_rd === 1'b1) && dmem));
        md   = MD_EN && ((id_md_read === 1'b1) || (id_md_start === 1'b1)) && (m_md_left[d] != 0);
        return lu || bo || md;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_md_left[d] = 0;
            m_pend[d]    = 1'b0;
            m_take[d]    = 1'b0;
            m_wait[d]    = 1'b0;
        end
        for (int i = 0; i <= IRQ_SYNC; i++) hist[i] = 1'b0;
    endtask

    task automatic model_edge(input bit s0, input bit s1);
        bit irq_s, rise, s, idle, np, nt, nw;
        if (reset === 1'b0) begin
            model_clear();
        end else begin
            irq_s = hist[IRQ_SYNC-1];
            rise  = irq_s && !hist[IRQ_SYNC];
            for (int d = 0; d < 2; d++) begin
                s    = (d == 0) ? s0 : s1;
                idle = !m_pend[d] && !m_take[d] && !m_wait[d];
                np   = (idle && rise) || (m_pend[d] && s);
                nt   = m_pend[d] && !s;
                nw   = m_take[d] || (m_wait[d] && irq_s);
                m_pend[d] = np;
                m_take[d] = nt;
                m_wait[d] = nw;
                if (MD_EN && (id_md_start === 1'b1) && !s) m_md_left[d] = MD_LAT;
                else if (m_md_left[d] > 0) m_md_left[d] = m_md_left[d] - 1;
            end
            for (int i = IRQ_SYNC; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = (irq === 1'b1);
        end
    endtask

    task automatic check_cycle(string tag);
        logic [5:0] got, exp;
        bit s, fl;
        for (int d = 0; d < 2; d++) begin
            s   = model_stall(d);
            fl  = !s && ((id_jump === 1'b1) || (id_branch === 1'b1 && id_br_taken === 1'b1) || m_take[d]);
            exp = {s, s, s, fl, m_take[d], (m_md_left[d] != 0)};
            got = {pc_stall[d], if_id_stall[d], id_ex_flush[d], if_id_flush[d], irq_take[d], md_busy[d]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s lat%0d {pc_stall,if_id_stall,id_ex_flush,if_id_flush,irq_take,md_busy} got=%b expected=%b",
                         tag, d + 1, got, exp);
            end
            last_stall[d] = (pc_stall[d] === 1'b1);
            last_take[d]  = (irq_take[d] === 1'b1);
            last_busy[d]  = (md_busy[d] === 1'b1);
        end
    endtask

    // Inputs are set at the falling edge; check, then advance one clock.
    task automatic step(string tag);
        bit s0, s1;
        #1;
        check_cycle(tag);
        s0 = model_stall(0);
        s1 = model_stall(1);
        @(posedge clk);
        model_edge(s0, s1);
        @(negedge clk);
    endtask

    task automatic check_val(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic set_idle();
        id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
        id_branch = 0; id_br_taken = 0; id_jump = 0; id_md_start = 0; id_md_read = 0;
        ex_mem_rd = 0; ex_reg_write = 0; ex_dst = '0;
        mem_mem_rd = 0; mem_reg_write = 0; mem_dst = '0; irq = 0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b0;
        step("do_reset");
        reset = 1'b1;
    endtask

    // lw $8 in EX, ID reads $8 in rs.
    task automatic load_use_on();
        ex_mem_rd = 1; ex_reg_write = 1; ex_dst = 5'd8; id_rs = 5'd8; id_use_rs = 1;
    endtask

    task automatic load_use_off();
        ex_mem_rd = 0; ex_reg_write = 0; ex_dst = '0; id_rs = '0; id_use_rs = 0;
    endtask

    task automatic add_vec(string n, int rs, int rt, bit urs, bit urt, bit br, bit tk, bit jmp,
                           bit mdrd, bit exmr, bit exrw, int exdst, bit memmr, int memdst,
                           bit s1, bit s2, bit f1, bit f2);
        vec_t v;
        v.name = n; v.rs = 5'(rs); v.rt = 5'(rt); v.urs = urs; v.urt = urt; v.br = br; v.tk = tk;
        v.jmp = jmp; v.mdrd = mdrd; v.exmr = exmr; v.exrw = exrw; v.exdst = 5'(exdst);
        v.memmr = memmr; v.memdst = 5'(memdst); v.s1 = s1; v.s2 = s2; v.f1 = f1; v.f2 = f2;
        vq.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, busy_cnt, first_take, take_cnt;
        logic [5:0] got, exp;

        //       name              rs rt urs urt br tk jmp mdrd exmr exrw exdst memmr memdst s1 s2 f1 f2
        add_vec("lw_use_ex",        8, 0, 1, 0,  0, 0, 0,  0,   1,   1,   8,    0,    0,     1, 1, 0, 0);
        add_vec("lw_r0",            0, 0, 1, 1,  0, 0, 0,  0,   1,   1,   0,    0,    0,     0, 0, 0, 0);
        add_vec("lw_use_mem",       3, 8, 1, 1,  0, 0, 0,  0,   0,   0,   0,    1,    8,     0, 1, 0, 0);
        add_vec("beq_ex_alu",       9, 3, 1, 1,  1, 1, 0,  0,   0,   1,   9,    0,    0,     1, 1, 0, 0);
        add_vec("add_ex_alu",       9, 3, 1, 1,  0, 0, 0,  0,   0,   1,   9,    0,    0,     0, 0, 0, 0);
        add_vec("beq_taken",        9, 3, 1, 1,  1, 1, 0,  0,   0,   0,   0,    0,    0,     0, 0, 1, 1);
        add_vec("beq_not_taken",    9, 3, 1, 1,  1, 0, 0,  0,   0,   1,   5,    0,    0,     0, 0, 0, 0);
        add_vec("jump",             0, 0, 0, 0,  0, 0, 1,  0,   0,   1,   4,    1,    4,     0, 0, 1, 1);
        add_vec("jr_lw_mem",       31, 0, 1, 0,  0, 0, 1,  0,   0,   0,   0,    1,   31,     1, 1, 0, 0);
        add_vec("jr_alu_mem",      31, 0, 1, 0,  0, 0, 1,  0,   0,   0,   0,    0,   31,     0, 0, 1, 1);
        add_vec("rs_not_used",      8, 0, 0, 0,  0, 0, 0,  0,   1,   1,   8,    0,    0,     0, 0, 0, 0);
        add_vec("mfhi_md_idle",     0, 0, 0, 0,  0, 0, 0,  1,   0,   0,   0,    0,    0,     0, 0, 0, 0);
        add_vec("beq_dst_r0",       0, 0, 1, 1,  1, 1, 0,  0,   0,   1,   0,    1,    0,     0, 0, 1, 1);
        add_vec("beq_lw_mem",       7, 2, 1, 1,  1, 0, 0,  0,   0,   0,   0,    1,    2,     1, 1, 0, 0);
        add_vec("jr_lw_ex",         5, 0, 1, 0,  0, 0, 1,  0,   1,   1,   5,    0,    0,     1, 1, 0, 0);

        // Power-up reset: state is unknown until the first reset edge.
        set_idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        model_clear();
        @(negedge clk);
        step("reset_state");
        reset = 1'b1;

        // Table of single-cycle hazard vectors from an idle controller.
        foreach (vq[i]) begin
            set_idle();
            id_rs = vq[i].rs; id_rt = vq[i].rt; id_use_rs = vq[i].urs; id_use_rt = vq[i].urt;
            id_branch = vq[i].br; id_br_taken = vq[i].tk; id_jump = vq[i].jmp; id_md_read = vq[i].mdrd;
            ex_mem_rd = vq[i].exmr; ex_reg_write = vq[i].exrw; ex_dst = vq[i].exdst;
            mem_mem_rd = vq[i].memmr; mem_reg_write = vq[i].memmr; mem_dst = vq[i].memdst;
            #1;
            for (int d = 0; d < 2; d++) begin
                exp = (d == 0) ? {vq[i].s1, vq[i].s1, vq[i].s1, vq[i].f1, 2'b00}
                               : {vq[i].s2, vq[i].s2, vq[i].s2, vq[i].f2, 2'b00};
                got = {pc_stall[d], if_id_stall[d], id_ex_flush[d], if_id_flush[d], irq_take[d], md_busy[d]};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL vec_%s lat%0d got=%b expected=%b", vq[i].name, d + 1, got, exp);
                end
            end
            step(vq[i].name);
        end

        // mult issued, mfhi three cycles later.
        do_reset();
        busy_cnt = 0;
        id_md_start = 1;
        step("md_issue");
        id_md_start = 0;
        for (int i = 0; i < 2; i++) begin
            step("md_gap");
            busy_cnt += int'(last_busy[0]);
        end
        id_md_read = 1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step("md_mfhi");
            busy_cnt += int'(last_busy[0]);
            if (last_stall[0]) cnt++;
            else break;
        end
        id_md_read = 0;
        for (int i = 0; i < 10; i++) begin
            step("md_tail");
            busy_cnt += int'(last_busy[0]);
        end
        check_val("md_mfhi_stall_cycles", cnt, MD_EN ? 6 : 0);
        check_val("md_busy_cycles", busy_cnt, MD_EN ? MD_LAT : 0);

        // irq edge to take latency: the first edge captures irq, then
        // IRQ_SYNC+1 further cycles.
        do_reset();
        irq = 1;
        first_take = -1;
        for (int i = 1; i <= 12; i++) begin
            step("irq_latency");
            if (last_take[0] && first_take < 0) first_take = i - 1;
        end
        check_val("irq_take_edges", first_take, IRQ_SYNC + 2);

        // irq raised during a held load-use stall, re-edge while pending,
        // take coincides with a jump, then request held high.
        do_reset();
        first_take = -1;
        take_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 1) begin irq = 1; load_use_on(); end
            if (i == 4) irq = 0;
            if (i == 5) irq = 1;
            if (i == 11) begin load_use_off(); id_jump = 1; end
            if (i == 13) id_jump = 0;
            step("irq_in_stall");
            if (last_take[0] && first_take < 0) first_take = i;
            take_cnt += int'(last_take[0]);
        end
        check_val("irq_stall_first_take_step", first_take, 12);
        check_val("irq_stall_take_count", take_cnt, 1);
        irq = 0;
        repeat (4) step("irq_release");

        // Reset while an interrupt is pending and the mult/div counter is at 5.
        do_reset();
        id_md_start = 1;
        irq = 1;
        step("rst_mid_issue");
        id_md_start = 0;
        load_use_on();
        repeat (3) step("rst_mid_hold");
        check_val("rst_mid_busy_before", int'(last_busy[0]), MD_EN ? 1 : 0);
        reset = 1'b0;
        irq = 0;
        step("rst_mid_reset");
        reset = 1'b1;
        step("rst_mid_after");
        check_val("rst_mid_irq_take", int'(last_take[0]), 0);
        check_val("rst_mid_md_busy", int'(last_busy[0]), 0);
        load_use_off();
        take_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step("rst_mid_drain");
            take_cnt += int'(last_take[0]);
        end
        check_val("rst_mid_no_take", take_cnt, 0);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 19) == 0) irq = ~irq;
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom_range(0, 1));
            id_use_rt    = 1'($urandom_range(0, 1));
            id_branch    = ($urandom_range(0, 3) == 0);
            id_br_taken  = 1'($urandom_range(0, 1));
            id_jump      = ($urandom_range(0, 5) == 0);
            id_md_start  = ($urandom_range(0, 7) == 0);
            id_md_read   = ($urandom_range(0, 5) == 0);
            ex_mem_rd    = ($urandom_range(0, 2) == 0);
            ex_reg_write = 1'($urandom_range(0, 1));
            ex_dst       = 5'($urandom_range(0, 3));
            mem_mem_rd   = ($urandom_range(0, 2) == 0);
            mem_reg_write = 1'($urandom_range(0, 1));
            mem_dst      = 5'($urandom_range(0, 3));
            step("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
